// File: rtl/seq_mult_hs_if.sv
// Operand/result handshake bundle for seq_mult_hs.
// Handshake: a transfer happens on a rising clock edge where valid && ready;
// the sender holds its payload stable while valid is high and ready is low.
interface seq_mult_hs_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic               signed_mode;
    logic [WIDTH-1:0]   mlier;
    logic [WIDTH-1:0]   mcand;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] prodt;
    logic               busy;

    modport master (
        output in_valid, signed_mode, mlier, mcand, out_ready,
        input  in_ready, out_valid, prodt, busy
    );

    modport slave (
        input  in_valid, signed_mode, mlier, mcand, out_ready,
        output in_ready, out_valid, prodt, busy
    );
endinterface

// File: rtl/seq_mult_hs.sv
// Sequential radix-2 shift/add multiplier, signed or unsigned per operation,
// with valid/ready on operands and result and a synchronous abort.
module seq_mult_hs #(
    parameter int WIDTH = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    seq_mult_hs_if.slave bus,
    output logic [1:0]   dbg_state_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0]   lier_q, lier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] prodt_q, prodt_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               out_fire;
    logic [WIDTH-1:0]   mag_lier;
    logic [WIDTH-1:0]   mag_cand;

    assign accept   = bus.in_valid && (state_q == S_IDLE);
    assign out_fire = out_valid_q && bus.out_ready;

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    assign mag_lier = (bus.signed_mode && bus.mlier[WIDTH-1]) ? -bus.mlier : bus.mlier;
    assign mag_cand = (bus.signed_mode && bus.mcand[WIDTH-1]) ? -bus.mcand : bus.mcand;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cand_d      = cand_q;
        lier_d      = lier_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        prodt_d     = prodt_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    cand_d  = {{WIDTH{1'b0}}, mag_cand};
                    lier_d  = mag_lier;
                    neg_d   = bus.signed_mode && (bus.mlier[WIDTH-1] ^ bus.mcand[WIDTH-1]);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (lier_q[0]) begin
                    acc_d = acc_q + cand_q;
                end
                cand_d = cand_q << 1;
                lier_d = lier_q >> 1;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                prodt_d     = neg_q ? -acc_q : acc_q;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Abort wins over accept and over the result handshake; the last
        // product register is left untouched.
        if (clear) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            prodt_d     = prodt_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cand_q      <= '0;
            lier_q      <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            prodt_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cand_q      <= cand_d;
            lier_q      <= lier_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            prodt_q     <= prodt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.prodt     = prodt_q;
    assign bus.busy      = (state_q == S_CALC) || (state_q == S_SIGN);
    assign dbg_state_o   = state_q;
endmodule

// File: doc/seq_mult_hs.md
Name: seq_mult_hs

Overview:
- Parametrised sequential radix-2 shift/add multiplier with run-time signed/unsigned mode.
- Uses a valid/ready handshake on both input and output, and holds the result under backpressure.
- Supports a synchronous abort.
- Sits between an operand producer and a consumer in the arithmetic datapath; one multiply in flight at a time.

Parameters:
- WIDTH, 32, operand width in bits; legal range 2..64; product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), derived localparam for the iteration counter; not overridable.

Ports:
- clock  in  1  rising-edge clock, the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; returns to IDLE and discards any operation in flight.
- in_valid  in  1  mlier/mcand/signed_mode are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- mlier  in  WIDTH  multiplier.
- mcand  in  WIDTH  multiplicand.
- out_valid  out  1  prodt holds a valid result.
- out_ready  in  1  consumer accepts the result.
- prodt  out  2*WIDTH  product.
- busy  out  1  high in CALC or SIGN.

Behaviour:
- Reset: reset_n low forces, immediately and asynchronously:
  - state = IDLE, prodt = 0, out_valid = 0, busy = 0.
  - All internal registers (acc, shift registers, counter, neg flag) = 0.
  - in_ready = 1 once reset_n is high.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - Accept occurs on a clock edge with in_valid & in_ready.
  - On accept:
    - mag_lier = (signed_mode & mlier[W-1]) ? -mlier : mlier; mag_cand likewise.
    - neg = signed_mode & (mlier[W-1] ^ mcand[W-1]).
    - acc = 0, cnt = 0, mcand shift register = {W'b0, mag_cand}.
    - Go to CALC.
- CALC, one iteration per cycle:
  - If the multiplier shift register LSB is 1, acc += mcand shift register (2W-bit add).
  - mcand shift register shifts left 1; multiplier shift register shifts right 1; cnt++.
  - When cnt == WIDTH-1 at the edge, go to SIGN; exactly WIDTH CALC cycles.
- SIGN:
  - prodt <= neg ? (~acc + 1) : acc; out_valid <= 1; go to DONE.
  - acc == 0 gives prodt = 0 regardless of neg.
- DONE:
  - out_valid = 1; prodt held stable until handshake.
  - On out_valid & out_ready at an edge: out_valid <= 0, go to IDLE. prodt keeps its last value and is don't-care while out_valid = 0.
- Latency:
  - out_valid rises WIDTH+1 edges after the accept edge: WIDTH CALC edges plus 1 SIGN edge.
  - Minimum issue interval is WIDTH+3 cycles: in_ready is 0 from the accept edge until the edge after the output handshake.
- Width rules:
  - Magnitude of -2^(W-1) is 2^(W-1), which fits in W unsigned bits.
  - Maximum signed product 2^(2W-2) and maximum unsigned product (2^W-1)^2 both fit in 2W bits; no overflow is possible.
  - Carries out of acc are discarded.
- clear:
  - clear high at an edge in any state: go to IDLE, out_valid <= 0, busy <= 0; no result is produced.
  - clear has priority over accept and over the output handshake in the same cycle.
  - prodt is not zeroed by clear.
- Simultaneous events:
  - in_valid in a non-IDLE state is ignored; the producer must hold its operands until in_ready.
  - out_ready while out_valid = 0 has no effect.
  - Input operand changes after accept have no effect.
- reset_n low mid-CALC aborts immediately; the block behaves as after power-up.

Test Plan (WIDTH=32):
- Signed: signed_mode=1, mlier=32'hFFFFFFFD (-3), mcand=7, out_ready=1 -> out_valid exactly 33 edges after accept, prodt=64'hFFFFFFFFFFFFFFEB; in_ready returns to 1 one edge after handshake.
- Unsigned vs signed: mlier=mcand=32'hFFFFFFFF:
  - signed_mode=0 -> prodt=64'hFFFFFFFE00000001.
  - signed_mode=1 -> prodt=64'h0000000000000001.
- Extremes, signed_mode=1:
  - 32'h80000000 x 32'h80000000 -> 64'h4000000000000000.
  - 32'h80000000 x 1 -> 64'hFFFFFFFF80000000.
  - 32'hFFFFFFFB (-5) x 0 -> 64'h0 (no negative zero).
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid=1, prodt stable, in_ready=0, and in_valid pulses ignored; then out_ready=1 -> out_valid=0 next edge, in_ready=1; a back-to-back second operation (12 x 12 unsigned -> 144) completes correctly.
- Abort:
  - clear=1 on the 5th CALC cycle -> IDLE next edge, busy=0, no out_valid.
  - clear with out_valid=1 and out_ready=1 in the same cycle -> IDLE, result dropped.
  - reset_n low mid-CALC -> outputs zero asynchronously; fresh multiply afterwards correct.
- Random: 1000 random operand/mode pairs with random out_ready stalls -> every prodt matches the reference model, and exactly one out_valid handshake per accept.
